// File: rtl/arbitri_2to1_if.sv
// Handshake bundle between two requesters and the 2:1 arbiter.
// The master modport is the requester side and the slave modport is the arbiter side.
interface arbitri_2to1_if #(
  parameter int unsigned W = 3
);
  logic         req0;
  logic [W-1:0] d0;
  logic         req1;
  logic [W-1:0] d1;
  logic         gnt0;
  logic         gnt1;
  logic         s;
  logic [W-1:0] z;
  logic         z_valid;

  modport master (
    output req0, d0, req1, d1,
    input  gnt0, gnt1, s, z, z_valid
  );

  modport slave (
    input  req0, d0, req1, d1,
    output gnt0, gnt1, s, z, z_valid
  );
endinterface

// File: rtl/arbitri_2to1.sv
// Two-requester arbiter with a bounded hold count and a registered output mux.
// Contention is resolved away from the last owner, and ownership can hand over without an idle cycle.
module arbitri_2to1 #(
  parameter int unsigned W        = 3,
  parameter int unsigned HOLD_MAX = 4   // legal range 1..15
) (
  input  logic         clk,
  input  logic         rst_n,
  arbitri_2to1_if.slave bus
);

  localparam int unsigned CW      = 4;
  localparam logic [CW-1:0] CNT_LIM = CW'(HOLD_MAX - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_last;
  logic [CW-1:0] r_cnt;
  logic          r_gnt0;
  logic          r_gnt1;
  logic          r_s;
  logic [W-1:0]  r_z;
  logic          r_z_valid;

  state_t        w_nxt;
  logic          w_xfer0;
  logic          w_xfer1;
  logic          w_hold_done;

  // Ownership decision: IDLE favours the side that did not own last; an owner yields on drop or quota.
  function automatic state_t f_next(input state_t st, input logic q0, input logic q1,
                                    input logic last, input logic hold_done);
    f_next = st;
    case (st)
      IDLE: begin
        if (q0 && q1)  f_next = last ? OWN0 : OWN1;
        else if (q0)   f_next = OWN0;
        else if (q1)   f_next = OWN1;
      end
      OWN0: begin
        if (!q0)                   f_next = q1 ? OWN1 : IDLE;
        else if (q1 && hold_done) f_next = OWN1;
      end
      OWN1: begin
        if (!q1)                   f_next = q0 ? OWN0 : IDLE;
        else if (q0 && hold_done) f_next = OWN0;
      end
      default: f_next = IDLE;
    endcase
  endfunction

  assign w_xfer0     = (r_state == OWN0) && bus.req0;
  assign w_xfer1     = (r_state == OWN1) && bus.req1;
  assign w_hold_done = (r_cnt == CNT_LIM);
  assign w_nxt       = f_next(r_state, bus.req0, bus.req1, r_last, w_hold_done);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_s       <= 1'b0;
      r_z       <= '0;
      r_z_valid <= 1'b0;
      r_cnt     <= '0;
      r_last    <= 1'b1;
    end else begin
      r_state   <= w_nxt;
      r_gnt0    <= (w_nxt == OWN0);
      r_gnt1    <= (w_nxt == OWN1);
      r_z_valid <= w_xfer0 | w_xfer1;
      if (w_xfer0)      r_z <= bus.d0;
      else if (w_xfer1) r_z <= bus.d1;

      // Counter restarts on any handover and saturates while the other side stays quiet.
      if (w_nxt != r_state) begin
        r_cnt <= '0;
        if (w_nxt == OWN0) begin
          r_last <= 1'b0;
          r_s    <= 1'b0;
        end else if (w_nxt == OWN1) begin
          r_last <= 1'b1;
          r_s    <= 1'b1;
        end
      end else if ((w_xfer0 | w_xfer1) && (r_cnt < CNT_LIM)) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign bus.gnt0    = r_gnt0;
  assign bus.gnt1    = r_gnt1;
  assign bus.s       = r_s;
  assign bus.z       = r_z;
  assign bus.z_valid = r_z_valid;

endmodule

// File: tb/tb_arbitri_2to1.sv
// Bench for arbitri_2to1: HOLD_MAX=4 and HOLD_MAX=1 instances, directed scenarios then random traffic,
// all compared against an ownership/tenure model of the arbitration rules.
module tb_arbitri_2to1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  arbitri_2to1_if #(.W(3)) bus4();
  arbitri_2to1_if #(.W(3)) bus1();

  arbitri_2to1 #(.W(3), .HOLD_MAX(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  arbitri_2to1 #(.W(3), .HOLD_MAX(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  logic       r0  [2];
  logic       r1  [2];
  logic [2:0] dd0 [2];
  logic [2:0] dd1 [2];

  assign bus4.req0 = r0[0];
  assign bus4.d0   = dd0[0];
  assign bus4.req1 = r1[0];
  assign bus4.d1   = dd1[0];
  assign bus1.req0 = r0[1];
  assign bus1.d0   = dd0[1];
  assign bus1.req1 = r1[1];
  assign bus1.d1   = dd1[1];

  // Model: owner (-1 none), transfers made in the current tenure, last owner, output copy.
  int         m_owner [2];
  int         m_run   [2];
  int         m_last  [2];
  logic [2:0] m_z     [2];
  logic       m_zv    [2];
  logic       m_s     [2];
  bit         m_xf0   [2];
  bit         m_xf1   [2];

  int n_checks = 0;
  int n_err    = 0;

  function automatic int hold_of(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
    n_checks++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic model_reset(input int k);
    m_owner[k] = -1;
    m_run[k]   = 0;
    m_last[k]  = 1;
    m_z[k]     = 3'd0;
    m_zv[k]    = 1'b0;
    m_s[k]     = 1'b0;
    m_xf0[k]   = 1'b0;
    m_xf1[k]   = 1'b0;
  endtask

  task automatic model_step(input int k);
    int nxt;
    bit mine;
    bit other;
    if (!rst_n) begin
      model_reset(k);
      return;
    end
    m_xf0[k] = (m_owner[k] == 0) && r0[k];
    m_xf1[k] = (m_owner[k] == 1) && r1[k];
    m_zv[k]  = m_xf0[k] || m_xf1[k];
    if (m_xf0[k])      m_z[k] = dd0[k];
    else if (m_xf1[k]) m_z[k] = dd1[k];
    if (m_owner[k] < 0) begin
      if (r0[k] && r1[k]) nxt = 1 - m_last[k];
      else if (r0[k])     nxt = 0;
      else if (r1[k])     nxt = 1;
      else                nxt = -1;
    end else begin
      mine  = (m_owner[k] == 0) ? r0[k] : r1[k];
      other = (m_owner[k] == 0) ? r1[k] : r0[k];
      if (!mine)                                       nxt = other ? 1 - m_owner[k] : -1;
      else if (other && (m_run[k] + 1 >= hold_of(k)))  nxt = 1 - m_owner[k];
      else                                             nxt = m_owner[k];
    end
    if (nxt != m_owner[k]) begin
      m_run[k] = 0;
      if (nxt >= 0) begin
        m_last[k] = nxt;
        m_s[k]    = (nxt == 1);
      end
    end else if (m_zv[k]) begin
      m_run[k]++;
    end
    m_owner[k] = nxt;
  endtask

  function automatic logic [6:0] dut_vec(input int k);
    if (k == 0) return {bus4.gnt0, bus4.gnt1, bus4.s, bus4.z_valid, bus4.z};
    return {bus1.gnt0, bus1.gnt1, bus1.s, bus1.z_valid, bus1.z};
  endfunction

  function automatic logic [6:0] mdl_vec(input int k);
    return {(m_owner[k] == 0), (m_owner[k] == 1), m_s[k], m_zv[k], m_z[k]};
  endfunction

  task automatic check_all(input string tag);
    logic [6:0] o;
    logic [6:0] e;
    for (int k = 0; k < 2; k++) begin
      o = dut_vec(k);
      e = mdl_vec(k);
      chk($sformatf("%s/h%0d/gnt0", tag, hold_of(k)), 8'(o[6]), 8'(e[6]));
      chk($sformatf("%s/h%0d/gnt1", tag, hold_of(k)), 8'(o[5]), 8'(e[5]));
      chk($sformatf("%s/h%0d/s", tag, hold_of(k)), 8'(o[4]), 8'(e[4]));
      chk($sformatf("%s/h%0d/z_valid", tag, hold_of(k)), 8'(o[3]), 8'(e[3]));
      chk($sformatf("%s/h%0d/z", tag, hold_of(k)), 8'(o[2:0]), 8'(e[2:0]));
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_all(tag);
  endtask

  task automatic set_both(input logic a, input logic [2:0] x, input logic b, input logic [2:0] y);
    for (int k = 0; k < 2; k++) begin
      r0[k]  = a;
      dd0[k] = x;
      r1[k]  = b;
      dd1[k] = y;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_both(1'b0, 3'd0, 1'b0, 3'd0);
    model_reset(0);
    model_reset(1);
    cycle("rst");
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_both(1'b0, 3'd0, 1'b0, 3'd0);
    model_reset(0);
    model_reset(1);
    #1;
    check_all("reset_async");
    cycle("reset");
    cycle("reset");
    rst_n = 1'b1;

    // Single requester: grant after one edge, data after the second.
    set_both(1'b1, 3'b101, 1'b0, 3'd0);
    cycle("r029_e1");
    chk("r029_gnt0", 8'(bus4.gnt0), 8'd1);
    cycle("r029_e2");
    chk("r029_z", 8'(bus4.z), 8'b101);
    chk("r029_zv", 8'(bus4.z_valid), 8'd1);
    chk("r029_s", 8'(bus4.s), 8'd0);
    set_both(1'b0, 3'd0, 1'b0, 3'd0);
    cycle("r029_drop");
    do_reset();

    // Continuous contention: quota of 4 vs alternate every transfer.
    set_both(1'b1, 3'b001, 1'b1, 3'b110);
    for (int i = 1; i <= 20; i++) begin
      cycle("r030");
      chk("r030_s", 8'(bus4.s), 8'(((i - 1) / 4) % 2));
      chk("r030_zv", 8'(bus4.z_valid), 8'(i >= 2));
      if (i >= 2) begin
        chk("r030_z", 8'(bus4.z), ((((i - 2) / 4) % 2) == 0) ? 8'd1 : 8'd6);
        chk("r032_z", 8'(bus1.z), ((i % 2) == 0) ? 8'd1 : 8'd6);
      end
    end
    do_reset();

    // Owner 1 releases with nobody waiting.
    set_both(1'b0, 3'd0, 1'b1, 3'b011);
    cycle("r031_e1");
    cycle("r031_e2");
    set_both(1'b0, 3'd0, 1'b0, 3'd0);
    cycle("r031_idle");
    chk("r031_gnt1", 8'(bus4.gnt1), 8'd0);
    chk("r031_zv", 8'(bus4.z_valid), 8'd0);
    chk("r031_s", 8'(bus4.s), 8'd1);
    do_reset();

    // Lone requester keeps the path; late contender takes over on the next edge.
    set_both(1'b1, 3'b010, 1'b0, 3'd0);
    for (int i = 1; i <= 10; i++) begin
      cycle("r034_solo");
      chk("r034_gnt0", 8'(bus4.gnt0), 8'd1);
    end
    set_both(1'b1, 3'b010, 1'b1, 3'b111);
    cycle("r034_sw");
    chk("r034_gnt1", 8'(bus4.gnt1), 8'd1);
    chk("r034_zlast0", 8'(bus4.z), 8'b010);
    cycle("r034_own1");
    chk("r034_z1", 8'(bus4.z), 8'b111);

    // Asynchronous reset between edges, then restart with requester 1 only.
    cycle("r033_burst");
    #3;
    rst_n = 1'b0;
    model_reset(0);
    model_reset(1);
    #1;
    check_all("r033_async");
    chk("r033_gnt0", 8'(bus4.gnt0), 8'd0);
    chk("r033_zv", 8'(bus4.z_valid), 8'd0);
    chk("r033_z", 8'(bus4.z), 8'd0);
    set_both(1'b0, 3'd0, 1'b1, 3'b100);
    cycle("r033_held");
    rst_n = 1'b1;
    cycle("r033_e1");
    chk("r033_own1", 8'(bus4.gnt1), 8'd1);
    chk("r033_own1_h1", 8'(bus1.gnt1), 8'd1);

    // Random traffic; a pending request stays up until it is served.
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 2; k++) begin
        if (!(r0[k] && !m_xf0[k])) r0[k] = ($urandom_range(0, 3) != 0);
        if (!(r1[k] && !m_xf1[k])) r1[k] = ($urandom_range(0, 3) != 0);
        dd0[k] = 3'($urandom);
        dd1[k] = 3'($urandom);
      end
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/arbitri_2to1.md
ARBITRI_2TO1 -- requirements
Module: arbitri_2to1

Interface
REQ-001 SHALL have parameter W, default 3: data width of each requester and of output z.
REQ-002 SHALL have parameter HOLD_MAX, default 4: max consecutive transfers per owner while the other side requests; legal range 1..15.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req0  input  1  requester 0 has valid data on d0; held high until granted.
REQ-006 SHALL have port d0  input  W  requester 0 data.
REQ-007 SHALL have port req1  input  1  requester 1 has valid data on d1; held high until granted.
REQ-008 SHALL have port d1  input  W  requester 1 data.
REQ-009 SHALL have port gnt0  output  1  requester 0 owns the shared path.
REQ-010 SHALL have port gnt1  output  1  requester 1 owns the shared path.
REQ-011 SHALL have port s  output  1  registered mux select: 0 = d0, 1 = d1.
REQ-012 SHALL have port z  output  W  registered output of the selected data.
REQ-013 SHALL have port z_valid  output  1  z holds a new transfer this cycle.

Function
REQ-014 SHALL implement FSM states IDLE, OWN0, OWN1; gnt0 = (state==OWN0), gnt1 = (state==OWN1), both registered (Moore); never both high.
REQ-015 SHALL treat a cycle with gntX=1 and reqX=1 as a transfer of dX.
REQ-016 SHALL, on a transfer edge, load z <= dX and set z_valid <= 1; latency is exactly 1 cycle from the transfer cycle to z/z_valid.
REQ-017 SHALL clear z_valid to 0 on any edge without a transfer; z holds its last value.
REQ-018 SHALL drive s = 0 in OWN0, s = 1 in OWN1, and hold the last value in IDLE.
REQ-019 SHALL keep a last-owner register `last`, updated to X on entry to OWNX.
REQ-020 SHALL transition IDLE: req0&req1 -> OWN of side != last; only req0 -> OWN0; only req1 -> OWN1; neither -> IDLE.
REQ-021 SHALL transition OWNX: reqX=0 and other req=1 -> OWN(other); reqX=0 and other req=0 -> IDLE.
REQ-022 SHALL transition OWNX with reqX=1 and other req=1 and cnt==HOLD_MAX-1 -> OWN(other); otherwise stay.
REQ-023 SHALL keep a transfer counter cnt (4 bits), incremented on each transfer while staying in the same state, cleared to 0 on any state change; saturates at HOLD_MAX-1 when the other side is idle.
REQ-024 SHALL, with HOLD_MAX=1 and both requesting continuously, alternate ownership after every transfer.
REQ-025 SHALL produce no transfer in the cycle of entering IDLE; ownership change costs zero idle cycles (OWN0 -> OWN1 directly).
REQ-026 SHALL ignore d0/d1 in cycles without a transfer from that side.

Reset
REQ-027 SHALL, while rst_n=0, immediately force state=IDLE, gnt0=gnt1=0, s=0, z=0, z_valid=0, cnt=0, last=1 (requester 0 wins the first contention).
REQ-028 SHALL, on reset mid-transfer, discard the in-flight data; first edge after release evaluates from IDLE.

Verification
REQ-029 SHALL cover: reset, then req0=1,d0=3'b101 -> gnt0=1 after 1 edge, z=101,z_valid=1 after 2nd edge, s=0.
REQ-030 SHALL cover: req0=req1=1 from reset held, HOLD_MAX=4 -> 4 transfers of d0, then 4 of d1, repeating; s toggles every 4 transfers, z_valid continuously 1 after first transfer.
REQ-031 SHALL cover: OWN1, req1 drops while req0=0 -> IDLE next edge, gnt1=0, z_valid=0, s stays 1.
REQ-032 SHALL cover: HOLD_MAX=1, req0=req1=1, d0=3'b001, d1=3'b110 -> z alternates 001,110,001,... every cycle.
REQ-033 SHALL cover: rst_n pulled low mid-burst (asynchronous, between edges) -> gnt0/gnt1/z/z_valid/s read 0 before next edge; after release with req1 only -> OWN1.
REQ-034 SHALL cover: only req0 for 10 cycles -> gnt0 never drops, cnt saturates at 3, no switch; req1 rises when cnt=3 -> OWN1 on next edge.
